// File: rtl/fifo_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_arbiter
// Purpose  : Round-robin arbiter sharing the read port of an async FIFO
//            (read-clock domain) among NUM_REQ consumers. One consumer at a
//            time gets a bounded burst of reads; returned data is steered
//            back to the consumer that issued each read.
// Ports    : rd_clk        read-domain clock (rising edge)
//            rd_rst_n      asynchronous active-low reset
//            req           per-consumer level read request
//            fifo_empty    empty flag from the read-pointer block
//            fifo_rd_data  FIFO read data, valid the cycle after fifo_rd_en
//            fifo_rd_en    read enable to the read-pointer block (comb.)
//            gnt           one-hot registered grant
//            rd_data       registered copy of fifo_rd_data
//            rd_valid      one-hot owner tag of the returned read
//            busy          high while a burst grant is active
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DW            = 8,
  parameter int MAX_BURST     = 8,
  parameter int EMPTY_TIMEOUT = 4
) (
  input  logic               rd_clk,
  input  logic               rd_rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               fifo_empty,
  input  logic [DW-1:0]      fifo_rd_data,
  output logic               fifo_rd_en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [DW-1:0]      rd_data,
  output logic [NUM_REQ-1:0] rd_valid,
  output logic               busy
);

  localparam int          IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0]  BURST_LAST = 4'(MAX_BURST - 1);
  localparam logic [3:0]  EMPTY_LAST = 4'(EMPTY_TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [3:0]           burst_cnt_q, burst_cnt_d;
  logic [3:0]           empty_cnt_q, empty_cnt_d;
  logic [NUM_REQ-1:0]   rd_valid_q;
  logic [DW-1:0]        rd_data_q;
  logic                 rst_sync_q;
  logic                 rd_en;
  logic                 sel_found;
  logic [IW-1:0]        sel_idx;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] i);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

  // Consumer index at offset k from the priority pointer, modulo NUM_REQ.
  function automatic logic [IW-1:0] rot_idx(input logic [IW-1:0] base, input int k);
    return IW'((int'(base) + k) % NUM_REQ);
  endfunction

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[rot_idx(ptr_q, k)]) begin
        sel_found = 1'b1;
        sel_idx   = rot_idx(ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    burst_cnt_d = burst_cnt_q;
    empty_cnt_d = empty_cnt_q;
    rd_en       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // rst_sync_q holds off the first grant until one edge after release.
        if (rst_sync_q && sel_found) begin
          idx_d       = sel_idx;
          gnt_d       = onehot(sel_idx);
          burst_cnt_d = '0;
          empty_cnt_d = '0;
          state_d     = ST_BURST;
        end
      end

      ST_BURST: begin
        rd_en = req[idx_q] & ~fifo_empty;
        if (rd_en) begin
          burst_cnt_d = burst_cnt_q + 4'd1;
          empty_cnt_d = '0;
        end else if (req[idx_q]) begin
          // Requesting but not reading means the FIFO is empty.
          empty_cnt_d = empty_cnt_q + 4'd1;
        end

        if ((rd_en && (burst_cnt_q == BURST_LAST)) ||
            !req[idx_q] ||
            (fifo_empty && (empty_cnt_q == EMPTY_LAST))) begin
          state_d     = ST_IDLE;
          gnt_d       = '0;
          burst_cnt_d = '0;
          empty_cnt_d = '0;
          ptr_d       = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      ptr_q       <= '0;
      gnt_q       <= '0;
      burst_cnt_q <= '0;
      empty_cnt_q <= '0;
      rd_valid_q  <= '0;
      rd_data_q   <= '0;
      rst_sync_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      burst_cnt_q <= burst_cnt_d;
      empty_cnt_q <= empty_cnt_d;
      rst_sync_q  <= 1'b1;
      // idx_q is still the issuing consumer at the read edge, even when the
      // grant drops at that same edge, so the last read is tagged correctly.
      rd_valid_q  <= rd_en ? onehot(idx_q) : '0;
      // FIFO data is valid in the cycle following a read.
      if (|rd_valid_q) begin
        rd_data_q <= fifo_rd_data;
      end
    end
  end

  assign fifo_rd_en = rd_en;
  assign gnt        = gnt_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign busy       = (state_q == ST_BURST);

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_arbiter
// Purpose  : Self-checking bench for fifo_rd_arbiter. A queue models the FIFO
//            contents; a transaction-level model (owner, reads done, empty
//            streak, pointer) predicts every output each cycle. Directed
//            scenarios pin the model with hand-computed values, followed by
//            randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 8;
  localparam int ET = 4;

  logic          rd_clk = 1'b0;
  logic          rd_rst_n;
  logic [NR-1:0] req;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_en;
  logic [NR-1:0] gnt;
  logic [DW-1:0] rd_data;
  logic [NR-1:0] rd_valid;
  logic          busy;

  fifo_rd_arbiter #(
    .NUM_REQ      (NR),
    .DW           (DW),
    .MAX_BURST    (MB),
    .EMPTY_TIMEOUT(ET)
  ) dut (
    .rd_clk      (rd_clk),
    .rd_rst_n    (rd_rst_n),
    .req         (req),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en  (fifo_rd_en),
    .gnt         (gnt),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .busy        (busy)
  );

  always #5 rd_clk = ~rd_clk;

  int checks = 0;
  int errors = 0;

  // FIFO contents and stimulus controls
  logic [DW-1:0] q[$];
  int            wr_cnt = 0;
  int            push_rate = 0;
  logic [NR-1:0] req_v = '0;
  bit            force_empty = 0;
  bit            tog = 0;

  // Behavioural model state
  bit            m_sync;
  bit            m_grant;
  int            m_own;
  int            m_ptr;
  int            m_reads;
  int            m_empties;
  logic [NR-1:0] m_valid;
  logic [DW-1:0] m_data;

  function automatic logic [NR-1:0] oh(input int i);
    return NR'(1) << i;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sync = 0; m_grant = 0; m_own = 0; m_ptr = 0;
    m_reads = 0; m_empties = 0; m_valid = '0; m_data = '0;
  endtask

  task automatic push_word();
    q.push_back(DW'(wr_cnt));
    wr_cnt++;
  endtask

  // One clock cycle: model advance at the rising edge, new inputs at the
  // falling edge, then compare every output against the model.
  task automatic step();
    bit            en;
    bit            popped;
    bit            done;
    bit            found;
    logic [DW-1:0] pop_w;
    logic          exp_en;
    @(posedge rd_clk);
    popped = 0;
    pop_w  = '0;
    if (rd_rst_n) begin
      en = m_grant && req[m_own] && !fifo_empty;
      if (m_valid != '0) m_data = fifo_rd_data;
      m_valid = en ? oh(m_own) : '0;
      if (en) begin
        pop_w  = q.pop_front();
        popped = 1;
      end
      if (!m_sync) begin
        m_sync = 1;
      end else if (!m_grant) begin
        found = 0;
        for (int k = 0; k < NR; k++) begin
          int j = (m_ptr + k) % NR;
          if (!found && req[j]) begin
            found = 1;
            m_own = j;
          end
        end
        if (found) begin
          m_grant = 1; m_reads = 0; m_empties = 0;
        end
      end else begin
        done = 0;
        if (en) begin
          m_reads++;
          m_empties = 0;
          if (m_reads == MB) done = 1;
        end else if (!req[m_own]) begin
          done = 1;
        end else begin
          m_empties++;
          if (m_empties == ET) done = 1;
        end
        if (done) begin
          m_grant = 0;
          m_ptr   = (m_own + 1) % NR;
        end
      end
    end
    #1;
    if (popped) fifo_rd_data = pop_w;
    @(negedge rd_clk);
    if (push_rate > 0 && $urandom_range(99) < push_rate) push_word();
    if (tog) force_empty = ~force_empty;
    req        = req_v;
    fifo_empty = (q.size() == 0) || force_empty;
    #1;
    exp_en = m_grant && req[m_own] && !fifo_empty;
    chk("fifo_rd_en", {31'd0, fifo_rd_en}, {31'd0, exp_en});
    chk("gnt",        {28'd0, gnt},        {28'd0, (m_grant ? oh(m_own) : 4'd0)});
    chk("busy",       {31'd0, busy},       {31'd0, m_grant});
    chk("rd_valid",   {28'd0, rd_valid},   {28'd0, m_valid});
    chk("rd_data",    {24'd0, rd_data},    {24'd0, m_data});
  endtask

  // Called right after a step (just past the falling edge): assert reset
  // between edges, optionally confirm outputs clear without a clock edge.
  task automatic apply_reset(input int cycles, input bit check_async);
    #2 rd_rst_n = 1'b0;
    #1;
    if (check_async) begin
      chk("async_rst_rd_en",    {31'd0, fifo_rd_en}, 32'd0);
      chk("async_rst_gnt",      {28'd0, gnt},        32'd0);
      chk("async_rst_rd_valid", {28'd0, rd_valid},   32'd0);
      chk("async_rst_busy",     {31'd0, busy},       32'd0);
    end
    model_reset();
    for (int i = 0; i < cycles; i++) step();
  endtask

  int            cnt_a;
  int            cnt_b;
  int            g_list[$];
  logic [NR-1:0] prev_g;
  int            exp_order[5] = '{1, 2, 4, 8, 1};
  int            rates[6] = '{90, 50, 20, 70, 35, 100};

  initial begin
    rd_rst_n     = 1'b0;
    req          = '0;
    fifo_empty   = 1'b1;
    fifo_rd_data = '0;
    model_reset();

    // ---- Reset state, then 20 words with consumer 0 requesting ----
    for (int i = 0; i < 20; i++) push_word();
    req_v = 4'b0001;
    for (int i = 0; i < 3; i++) step();
    chk("reset_gnt",      {28'd0, gnt},        32'd0);
    chk("reset_rd_valid", {28'd0, rd_valid},   32'd0);
    chk("reset_rd_data",  {24'd0, rd_data},    32'd0);
    chk("reset_rd_en",    {31'd0, fifo_rd_en}, 32'd0);
    chk("reset_busy",     {31'd0, busy},       32'd0);
    rd_rst_n = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int s = 1; s <= 11; s++) begin
      step();
      if (s == 1) chk("first_edge_no_grant", {28'd0, gnt}, 32'd0);
      if (s <= 10 && gnt == 4'b0001)      cnt_a++;
      if (s <= 10 && rd_valid == 4'b0001) cnt_b++;
      if (s == 10) chk("idle_between_grants", {28'd0, gnt}, 32'd0);
      if (s == 11) begin
        chk("regrant_c0",     {28'd0, gnt},     32'd1);
        chk("last_word_data", {24'd0, rd_data}, 32'd7);
      end
    end
    chk("burst_gnt_cycles", cnt_a, 32'd8);
    chk("burst_valid_cnt",  cnt_b, 32'd8);

    // ---- All consumers requesting, FIFO never empty ----
    apply_reset(2, 0);
    push_rate = 100;
    req_v = 4'b1111;
    rd_rst_n = 1'b1;
    prev_g = '0;
    for (int s = 1; s <= 60; s++) begin
      step();
      if (gnt != prev_g && gnt != '0) g_list.push_back(int'(gnt));
      prev_g = gnt;
    end
    chk("grant_count_ge5", {31'd0, (g_list.size() >= 5)}, 32'd1);
    for (int i = 0; i < 5 && i < g_list.size(); i++)
      chk("grant_order", g_list[i], exp_order[i]);

    // ---- Consumer 1, 3 words, empty timeout; then 2 drops req; reset ----
    apply_reset(2, 0);
    push_rate = 0;
    q.delete();
    for (int i = 0; i < 3; i++) push_word();
    req_v = 4'b0010;
    rd_rst_n = 1'b1;
    cnt_a = 0;
    for (int s = 1; s <= 19; s++) begin
      step();
      if (s <= 9 && fifo_rd_en) cnt_a++;
      if (s == 8) begin
        chk("timeout_gnt_held", {28'd0, gnt}, 32'h2);
        req_v = 4'b1111;
        for (int i = 0; i < 20; i++) push_word();
      end
      if (s == 9)  chk("timeout_gnt_drop", {28'd0, gnt}, 32'h0);
      if (s == 10) chk("ptr_after_timeout", {28'd0, gnt}, 32'h4);
      if (s == 14) req_v = 4'b1011;
      if (s == 15) chk("no_sixth_read", {31'd0, fifo_rd_en}, 32'd0);
      if (s == 16) chk("drop_gnt_clear", {28'd0, gnt}, 32'h0);
      if (s == 17) chk("next_grant_c3",  {28'd0, gnt}, 32'h8);
    end
    chk("timeout_reads", cnt_a, 32'd3);
    apply_reset(2, 1);
    req_v = 4'b1111;
    rd_rst_n = 1'b1;
    step();
    step();
    chk("restart_from_c0", {28'd0, gnt}, 32'h1);

    // ---- Empty toggling every cycle during a grant ----
    apply_reset(2, 0);
    q.delete();
    for (int i = 0; i < 20; i++) push_word();
    req_v = 4'b0100;
    rd_rst_n = 1'b1;
    step();
    force_empty = 1;
    tog = 1;
    cnt_a = 0;
    for (int s = 2; s <= 17; s++) begin
      step();
      if (s <= 16 && fifo_rd_en) cnt_a++;
      if (s == 16) chk("toggle_gnt_held", {28'd0, gnt}, 32'h4);
      if (s == 17) chk("toggle_gnt_drop", {28'd0, gnt}, 32'h0);
    end
    chk("toggle_reads", cnt_a, 32'd8);
    tog = 0;
    force_empty = 0;

    // ---- Randomized traffic ----
    apply_reset(2, 0);
    rd_rst_n = 1'b1;
    for (int s = 0; s < 3000; s++) begin
      push_rate = rates[(s / 500) % 6];
      if ($urandom_range(7) == 0) req_v = NR'($urandom_range(0, 15));
      force_empty = ($urandom_range(9) == 0);
      step();
      if (s == 1500) begin
        apply_reset(2, 1);
        rd_rst_n = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
